// File: rtl/sr_bank.sv
// sr_bank: WIDTH-channel SR flag bank with selectable s=r=1 response, edge pulses, optional conflict counter (SR_BANK_CONFLICT_CNT_EN)
module sr_bank #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CONFLICT_MODE = 0,
    parameter logic [31:0] INIT          = '0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];
    logic [WIDTH-1:0] q_q, q_d, rise_q, fall_q, both, cf_val;
    logic             conflict_q, conflict_d;
    // next state: set/reset/hold, with the instance-selected answer for s=r=1
    always_comb begin
        both       = s & r;
        cf_val     = CONFLICT_MODE == 1 ? '1 : CONFLICT_MODE == 2 ? '0 : CONFLICT_MODE == 3 ? ~q_q : q_q;
        q_d        = en ? ((s & ~r) | (~s & ~r & q_q) | (both & cf_val)) : q_q;
        conflict_d = en & |both;
    end
    // state, edge pulses and conflict flag all land on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q        <= INIT_V;
            rise_q     <= '0;
            fall_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            rise_q     <= q_d & ~q_q;
            fall_q     <= ~q_d & q_q;
            conflict_q <= conflict_d;
        end
    end
`ifdef SR_BANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // clear wins over increment; saturate instead of wrapping
    always_comb begin
        cnt_d = clr_cnt ? '0 : (conflict_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    // conflict counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign conflict_cnt = cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign conflict_cnt   = '0;
`endif
    assign q        = q_q;
    assign q_rise   = rise_q;
    assign q_fall   = fall_q;
    assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_bank.sv
// tb_sr_bank: scoreboard bench driving four WIDTH=4 instances (one per conflict mode) against a per-channel reference model
module tb_sr_bank;
    logic        clk = 1'b0, reset = 1'b1, en = 1'b0, clr_cnt = 1'b0;
    logic [3:0]  s = '0, r = '0;
    logic [15:0] q_all, rise_all, fall_all;
    logic [3:0]  conf_all;
    logic [11:0] cnt_all;
    int          total = 0, bad = 0;
    event        rst_ev;

    typedef struct {
        logic [15:0] q, rise, fall;
        logic [3:0]  conf;
        logic [11:0] cnt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sr_bank #(.WIDTH(4), .CONFLICT_MODE(g), .INIT(32'b1010), .CNT_W(3)) u_dut (
            .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .clr_cnt(clr_cnt),
            .q(q_all[g*4+:4]), .q_rise(rise_all[g*4+:4]), .q_fall(fall_all[g*4+:4]),
            .conflict(conf_all[g]), .conflict_cnt(cnt_all[g*3+:3])
        );
    end

    logic [3:0] mq[4];
    int         mc[4];
    exp_t       cur;

    function automatic exp_t snapshot(input logic [3:0] rise[4], input logic [3:0] fall[4], input logic conf);
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            e.q[m*4+:4]    = mq[m];
            e.rise[m*4+:4] = rise[m];
            e.fall[m*4+:4] = fall[m];
            e.conf[m]      = conf;
            e.cnt[m*3+:3]  = 3'(mc[m]);
        end
        return e;
    endfunction

    task automatic model_reset();
        logic [3:0] z[4];
        for (int m = 0; m < 4; m++) begin
            mq[m] = 4'b1010;
            mc[m] = 0;
            z[m]  = '0;
        end
        sb.push_back(snapshot(z, z, 1'b0));
    endtask

    task automatic model_edge(input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic c);
        logic [3:0] rise[4], fall[4];
        logic       hit;
        hit = e && ((sv & rv) != 0);
        for (int m = 0; m < 4; m++) begin
            logic [3:0] nq;
            for (int i = 0; i < 4; i++) begin
                logic old;
                old = mq[m][i];
                if (!e)                     nq[i] = old;
                else if (sv[i] && !rv[i])   nq[i] = 1'b1;
                else if (!sv[i] && rv[i])   nq[i] = 1'b0;
                else if (!sv[i] && !rv[i])  nq[i] = old;
                else if (m == 1)            nq[i] = 1'b1;
                else if (m == 2)            nq[i] = 1'b0;
                else if (m == 3)            nq[i] = !old;
                else                        nq[i] = old;
                rise[m][i] = nq[i] && !old;
                fall[m][i] = !nq[i] && old;
            end
            mq[m] = nq;
`ifdef SR_BANK_CONFLICT_CNT_EN
            if (c) mc[m] = 0;
            else if (hit && mc[m] < 7) mc[m] = mc[m] + 1;
`else
            mc[m] = 0;
`endif
        end
        sb.push_back(snapshot(rise, fall, hit));
    endtask

    task automatic cyc(input logic rl, input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic c);
        @(negedge clk);
        reset = rl; en = e; s = sv; r = rv; clr_cnt = c;
        if (!rl) model_reset();
        else model_edge(e, sv, rv, c);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        -> rst_ev;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk or rst_ev);
            #1;
            while (sb.size() > 0) begin
                cur = sb.pop_front();
                chk("q", q_all, cur.q);
                chk("q_rise", rise_all, cur.rise);
                chk("q_fall", fall_all, cur.fall);
                chk("conflict", {12'b0, conf_all}, {12'b0, cur.conf});
                chk("conflict_cnt", {4'b0, cnt_all}, {4'b0, cur.cnt});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        async_reset();
        cyc(1, 1, 4'h0, 4'h0, 0);
        repeat (2) cyc(1, 1, 4'h0, 4'h0, 0);
        cyc(1, 1, 4'h0, 4'hF, 0);
        cyc(1, 1, 4'b0101, 4'h0, 0);
        cyc(1, 1, 4'h0, 4'b0100, 0);
        cyc(1, 1, 4'b0011, 4'b1100, 0);
        repeat (2) cyc(1, 1, 4'hF, 4'hF, 0);
        cyc(1, 1, 4'b0011, 4'b1100, 0);
        repeat (5) cyc(1, 0, 4'hF, 4'h0, 0);
        cyc(1, 1, 4'hF, 4'h0, 0);
        cyc(1, 1, 4'h0, 4'h0, 1);
        repeat (10) cyc(1, 1, 4'hF, 4'hF, 0);
        cyc(1, 1, 4'hF, 4'hF, 1);
        cyc(1, 1, 4'hF, 4'hF, 0);
        cyc(1, 1, 4'hF, 4'hF, 0);
        async_reset();
        cyc(1, 1, 4'hF, 4'hF, 0);
        cyc(1, 1, 4'hF, 4'hF, 0);
        async_reset();
        cyc(0, 1, 4'hF, 4'hF, 0);
        cyc(1, 1, 4'hF, 4'hF, 0);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(49) == 0) async_reset();
            cyc(1, $urandom_range(3) != 0, 4'($urandom), 4'($urandom), $urandom_range(15) == 0);
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_bank.md
Name: sr_bank

Overview:
- Parametrised, multi-channel successor to the single-bit SR flip-flop with asynchronous reset.
- Provides WIDTH independent SR storage cells with a common enable.
- The response to s=r=1 is selected per instance: hold, set-dominant, reset-dominant or toggle (JK).
- Adds registered rise/fall pulses per channel and a conflict indicator with an optional saturating counter. Used as a status/flag register bank in control logic.

Parameters:
WIDTH, 8, number of SR channels (1..32)
CONFLICT_MODE, 0, s=r=1 behaviour: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
INIT, 0, WIDTH-bit reset value loaded into q
CNT_W, 8, width of conflict counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  update enable; 0 freezes q
s  input  WIDTH  per-channel set
r  input  WIDTH  per-channel reset
clr_cnt  input  1  synchronous clear of conflict_cnt
q  output  WIDTH  stored state
q_rise  output  WIDTH  one-cycle pulse, channel went 0->1 at this edge
q_fall  output  WIDTH  one-cycle pulse, channel went 1->0 at this edge
conflict  output  1  registered: some channel had s=r=1 while en=1 last edge
conflict_cnt  output  CNT_W  saturating count of conflict cycles

Behaviour:
- reset=0 (asynchronous, any time, including mid-operation) forces these values immediately, independent of clk: q=INIT, q_rise=0, q_fall=0, conflict=0, conflict_cnt=0.
- Release of reset is asynchronous. The first update happens at the first rising edge with reset=1.
- All updates occur on the rising clk edge. Latency is 1 cycle from s/r to q.
- Per channel i with en=1, computing next q:
  - s=0, r=0: hold.
  - s=1, r=0: 1.
  - s=0, r=1: 0.
  - s=1, r=1: per CONFLICT_MODE (0 hold, 1 one, 2 zero, 3 ~q[i]).
- en=0: q holds regardless of s/r. conflict is 0 at that edge and no count occurs.
- q_rise[i] = nq[i] & ~q[i] and q_fall[i] = ~nq[i] & q[i], registered at the same edge as q. Pulses are therefore coincident with the cycle in which q shows the new value and last exactly one cycle unless q changes again.
- conflict is registered at each edge as en & |(s & r).
- Conflict counter (when compiled in):
  - Priority: clr_cnt over increment.
  - clr_cnt=1 sets it to 0, even if a conflict occurs at the same edge.
  - Otherwise it increments by 1 on each edge where en & |(s & r).
  - It saturates at 2^CNT_W-1 and never wraps.
- Multiple channels in conflict in one cycle count as one.
- No combinational path from inputs to outputs. All outputs are registered.
- INIT wider than WIDTH is truncated to the low WIDTH bits.

Optional Feature:
- Macro: SR_BANK_CONFLICT_CNT_EN.
- Defined: the conflict counter is implemented as described above.
- Not defined:
  - No counter flops are synthesised.
  - conflict_cnt is tied to constant 0.
  - clr_cnt is ignored.
  - The conflict output is still present and behaves identically.

Test Plan:
- Reset/INIT: WIDTH=4, INIT=4'b1010, assert reset=0 mid-cycle between edges -> q=1010 immediately, q_rise=q_fall=0, conflict_cnt=0. Release, then s=0,r=0 for 3 edges -> q stays 1010.
- Set/clear and pulses: from q=0000, s=0101 for 1 edge -> q=0101, q_rise=0101 for one cycle. Then r=0100 -> q=0001, q_fall=0100 for one cycle, q_rise=0000.
- Conflict modes: s=r=4'b1111 with q=0011 applied for 2 edges in each mode:
  - mode 0 -> 0011, 0011;
  - mode 1 -> 1111, 1111;
  - mode 2 -> 0000, 0000;
  - mode 3 -> 1100, then 0011, with rise/fall pulses on every toggle.
- Enable freeze: en=0, s=1111, r=0000 for 5 edges -> q unchanged, no pulses, conflict=0. Raise en -> q=1111 after 1 edge.
- Counter (macro defined, CNT_W=3): 10 consecutive conflict edges -> conflict_cnt 1..7, then holds at 7. clr_cnt=1 together with a conflict -> 0. Next conflict edge -> 1. Macro undefined: same stimulus -> conflict_cnt stays 0 while conflict still pulses.
- Async reset mid-toggle: mode 3, s=r=1111, assert reset=0 between edges -> q=INIT at once, q_rise/q_fall=0. After release, toggling resumes from INIT.
